wordle_round_ctrl: RTL
======================

Name: wordle_round_ctrl

Overview:
Sequences one Wordle game around the processor/regfile datapath.
- Collects keyboard letters into a 5-slot guess buffer and publishes the guess letters (guess0..4) plus the guess counter that the regfile maps into the processor.
- Hands the guess to the processor by incrementing counter, then runs a two-phase handshake on the regfile readysignal (rdy).
- Latches the five returned colours for the VGA row, and tracks win/loss over MAX_GUESSES rounds.

Parameters:
MAX_GUESSES, 6, rounds before loss (1..31).
COLOR_GREEN, 12'h0F0, colour code meaning exact letter match.
TIMEOUT_CYCLES, 65535, max cycles spent in each wait state before error.

Ports:
clock  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
key_valid  in  1  one-cycle strobe, key event present.
key_code  in  8  ASCII letter, sampled when key_valid.
key_back  in  1  backspace, sampled when key_valid.
key_enter  in  1  submit, sampled when key_valid.
proc_rdy  in  1  regfile readysignal; high = colours valid.
color_in0..color_in4  in  12 each  colours from processor.
guess0..guess4  out  8 each  current guess letters to regfile/VGA (0 = empty).
counter  out  5  number of submitted guesses; regfile input.
row_color0..row_color4  out  12 each  latched colours of last evaluated row.
row_valid  out  1  one-cycle pulse when row_color* update.
entry_pos  out  3  number of letters currently entered (0..5).
busy  out  1  high from submit until latch completes.
win  out  1  sticky, game won.
lose  out  1  sticky, game lost.
err  out  1  sticky, handshake timeout.

Behaviour:
Reset (async, any state):
- All outputs become 0; state becomes ENTRY.
- A reset mid-handshake abandons the round; counter returns to 0.

ENTRY state, on key_valid:
- Priority is enter > back > letter when several are asserted together.
- Letter: accepted only if key_code is 0x41..0x5A and entry_pos<5. It is written to guess[entry_pos] and entry_pos increments. Any other code, or a full buffer, is ignored.
- Back: if entry_pos>0, entry_pos decrements and that slot is cleared to 0. At entry_pos=0 it is ignored.
- Enter: if entry_pos==5, go to SUBMIT. Otherwise ignored.

SUBMIT (1 cycle):
- counter <= counter+1 and busy <= 1.
- guess0..4 hold stable until LATCH.
- Go to WAIT_LOW.

WAIT_LOW:
- Wait for proc_rdy==0 (processor has seen the new counter).
- If proc_rdy is already 0 on entry, leave after 1 cycle.
- Then go to WAIT_HIGH.

WAIT_HIGH:
- Wait for proc_rdy==1, then go to LATCH.

Timeout:
- A cycle counter is cleared on entry to each wait state.
- If it reaches TIMEOUT_CYCLES, err <= 1, busy <= 0, go to ERROR.
- ERROR is terminal until reset.

LATCH (1 cycle):
- row_color* <= color_in* and row_valid pulses high for this cycle only.
- busy <= 0.
- If all five color_in == COLOR_GREEN: win <= 1, go to DONE.
- Else if counter == MAX_GUESSES: lose <= 1, go to DONE.
- Else clear guess0..4 and entry_pos, go to ENTRY.
- Win takes precedence over lose on the final round.

DONE:
- All key input is ignored; outputs hold until reset.

Latency:
- From an accepted enter to the counter change: 1 cycle.
- From the proc_rdy rise to row_valid: 1 cycle.

Width:
- counter never exceeds MAX_GUESSES and does not wrap.

Decomposition:
Package wordle_pkg holds:
- State enum: ENTRY, SUBMIT, WAIT_LOW, WAIT_HIGH, LATCH, DONE, ERROR.
- ASCII_A=8'h41 and ASCII_Z=8'h5A.
- The default COLOR_GREEN.
- The guess array type (5 x 8 bit).

One sub-module, guess_entry_buf, owns the 5-slot letter buffer and entry_pos:
- Inputs: letter/back strobes, clear.
- Outputs: guesses, pos, full.
The FSM, timeout counter and colour latch stay in the top module.

Test Plan:
1. Keys "C","R","A","N","E", enter; proc_rdy 1->0->1 with all colours 12'h0F0 -> counter=1, guess="CRANE", row_valid 1 cycle, win=1; further keys ignored.
2. Keys "A","B", back, "Z", then enter -> guess0=0x41, guess1=0x5A, entry_pos=2; enter ignored, counter stays 0.
3. Six full guesses, each answered with at least one non-green colour (e.g. 12'h888) -> counter=6, lose=1 after the 6th row_valid, win=0.
4. Submit, then hold proc_rdy=1 for TIMEOUT_CYCLES cycles -> err=1, busy=0; keys ignored until reset.
5. Assert reset during WAIT_HIGH with counter=3 -> counter, guess*, row_color*, busy all read 0 asynchronously; next letter lands in guess0.
6. Same-cycle key_enter+key_back with 5 letters -> submit wins (counter+1); key_code 0x61 ('a') and 0x30 ignored; 6th letter with buffer full ignored.

Source files
------------

// File: rtl/wordle_pkg.sv
// Shared types and constants for the Wordle round controller.
package wordle_pkg;

    localparam logic [7:0]  ASCII_A          = 8'h41;
    localparam logic [7:0]  ASCII_Z          = 8'h5A;
    localparam logic [11:0] COLOR_GREEN_DFLT = 12'h0F0;
    localparam int          NUM_SLOTS        = 5;

    typedef enum logic [2:0] {
        ENTRY,
        SUBMIT,
        WAIT_LOW,
        WAIT_HIGH,
        LATCH,
        DONE,
        ERROR
    } state_t;

    typedef logic [NUM_SLOTS-1:0][7:0] guess_arr_t;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

endpackage

// File: rtl/wordle_round_ctrl_guess_entry_buf.sv
// Five-slot letter buffer with write pointer; letter has priority over back.
module guess_entry_buf
    import wordle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       letter_stb,
    input  logic [7:0] letter,
    input  logic       back_stb,
    input  logic       clear,
    output guess_arr_t guesses,
    output logic [2:0] pos,
    output logic       full
);

    assign full = (pos == 3'd5);

    // Write, erase or wipe slots; the pointer always names the next free slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            guesses <= '0;
            pos     <= 3'd0;
        end else if (clear) begin
            guesses <= '0;
            pos     <= 3'd0;
        end else if (letter_stb && !full) begin
            guesses[pos] <= letter;
            pos          <= pos + 3'd1;
        end else if (back_stb && (pos != 3'd0)) begin
            guesses[pos - 3'd1] <= 8'h00;
            pos                 <= pos - 3'd1;
        end
    end

endmodule

// File: rtl/wordle_round_ctrl.sv
// Round sequencer: letter entry, counter handoff, rdy handshake, colour latch.
//
// state     | meaning
// ----------+--------------------------------------------------
// ENTRY     | collecting letters from the keyboard
// SUBMIT    | bump counter so the processor sees a new guess
// WAIT_LOW  | waiting for rdy to drop (processor took the guess)
// WAIT_HIGH | waiting for rdy to rise (colours valid)
// LATCH     | row colours published, win/lose decided
// DONE      | game over, keys ignored until reset
// ERROR     | handshake timed out, terminal until reset
module wordle_round_ctrl
    import wordle_pkg::*;
#(
    parameter int          MAX_GUESSES    = 6,
    parameter logic [11:0] COLOR_GREEN    = COLOR_GREEN_DFLT,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic        key_back,
    input  logic        key_enter,
    input  logic        proc_rdy,
    input  logic [11:0] color_in0,
    input  logic [11:0] color_in1,
    input  logic [11:0] color_in2,
    input  logic [11:0] color_in3,
    input  logic [11:0] color_in4,
    output logic [7:0]  guess0,
    output logic [7:0]  guess1,
    output logic [7:0]  guess2,
    output logic [7:0]  guess3,
    output logic [7:0]  guess4,
    output logic [4:0]  counter,
    output logic [11:0] row_color0,
    output logic [11:0] row_color1,
    output logic [11:0] row_color2,
    output logic [11:0] row_color3,
    output logic [11:0] row_color4,
    output logic        row_valid,
    output logic [2:0]  entry_pos,
    output logic        busy,
    output logic        win,
    output logic        lose,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state, state_next;
    logic [TW-1:0]     tmo_cnt;
    logic              tmo_done;
    logic [4:0][11:0]  row_col;
    logic              all_green;
    logic              last_round;
    logic              in_entry;
    logic              letter_stb, back_stb, buf_clear, buf_full;
    guess_arr_t        guesses;

    assign in_entry   = (state == ENTRY) && key_valid;
    assign letter_stb = in_entry && !key_enter && !key_back && is_letter(key_code);
    assign back_stb   = in_entry && !key_enter && key_back;
    assign buf_clear  = (state == LATCH) && (state_next == ENTRY);
    assign tmo_done   = (tmo_cnt == '0);
    assign last_round = (counter == 5'(MAX_GUESSES));
    assign all_green  = (row_col[0] == COLOR_GREEN) && (row_col[1] == COLOR_GREEN) &&
                        (row_col[2] == COLOR_GREEN) && (row_col[3] == COLOR_GREEN) &&
                        (row_col[4] == COLOR_GREEN);

    guess_entry_buf u_buf (
        .clock      (clock),
        .reset      (reset),
        .letter_stb (letter_stb),
        .letter     (key_code),
        .back_stb   (back_stb),
        .clear      (buf_clear),
        .guesses    (guesses),
        .pos        (entry_pos),
        .full       (buf_full)
    );

    assign guess0 = guesses[0];
    assign guess1 = guesses[1];
    assign guess2 = guesses[2];
    assign guess3 = guesses[3];
    assign guess4 = guesses[4];

    assign row_color0 = row_col[0];
    assign row_color1 = row_col[1];
    assign row_color2 = row_col[2];
    assign row_color3 = row_col[3];
    assign row_color4 = row_col[4];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ENTRY;
        else       state <= state_next;
    end

    // Next-state decode; a satisfied handshake beats a same-cycle timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            ENTRY:     if (key_valid && key_enter && buf_full) state_next = SUBMIT;
            SUBMIT:    state_next = WAIT_LOW;
            WAIT_LOW:  if (!proc_rdy)     state_next = WAIT_HIGH;
                       else if (tmo_done) state_next = ERROR;
            WAIT_HIGH: if (proc_rdy)      state_next = LATCH;
                       else if (tmo_done) state_next = ERROR;
            LATCH:     if (all_green || last_round) state_next = DONE;
                       else                         state_next = ENTRY;
            DONE:      state_next = DONE;
            ERROR:     state_next = ERROR;
            default:   state_next = ENTRY;
        endcase
    end

    // Outputs decoded directly from state.
    always_comb begin
        busy      = 1'b0;
        row_valid = 1'b0;
        err       = 1'b0;
        unique case (state)
            WAIT_LOW, WAIT_HIGH: busy = 1'b1;
            LATCH: begin
                busy      = 1'b1;
                row_valid = 1'b1;
            end
            ERROR:   err = 1'b1;
            default: ;
        endcase
    end

    // Counter, wait timer (reloaded on entry to each wait), colour latch and result flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter <= 5'd0;
            tmo_cnt <= '0;
            row_col <= '0;
            win     <= 1'b0;
            lose    <= 1'b0;
        end else begin
            if (state == SUBMIT && counter < 5'(MAX_GUESSES))
                counter <= counter + 5'd1;

            if (state == SUBMIT || (state == WAIT_LOW && !proc_rdy))
                tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
            else if ((state == WAIT_LOW || state == WAIT_HIGH) && !tmo_done)
                tmo_cnt <= tmo_cnt - 1'b1;

            if (state == WAIT_HIGH && proc_rdy)
                row_col <= {color_in4, color_in3, color_in2, color_in1, color_in0};

            if (state == LATCH) begin
                if (all_green)       win  <= 1'b1;
                else if (last_round) lose <= 1'b1;
            end
        end
    end

endmodule
